ahb3lite_timer: RTL and testbench
=================================

AHB3LITE_TIMER -- requirements
Module: ahb3lite_timer

Interface
REQ-001 SHALL have parameter g_haddr_size, default 32, AHB address width.
REQ-002 SHALL have parameter g_hdata_size, default 32, AHB data width; only 32 is supported.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports: hclk_i in 1, the single clock; rst_i in 1, synchronous active-high reset.
REQ-004 hsel_i in 1: slave select from the interconnect.
REQ-005 haddr_i in g_haddr_size: transfer address; only bits [4:2] are decoded.
REQ-006 hwdata_i in g_hdata_size: write data, valid in the data phase.
REQ-007 hrdata_o out g_hdata_size: read data, driven in the data phase.
REQ-008 hwrite_i in 1, hsize_i in 3, hburst_i in 3, hprot_i in 4, htrans_i in 2: AHB3-Lite control; hburst_i and hprot_i are ignored.
REQ-009 hready_i in 1: combined bus ready.
REQ-010 hreadyout_o out 1: slave ready.
REQ-011 hresp_o out 1: response.
REQ-012 irq_o out 1: level interrupt to Cortex-M0 irq_i[0].

Function
REQ-013 Register map, word offsets:
- 0x00 CTRL, RW: bit0 EN, bit1 IRQEN, bit2 AUTO, other bits read 0.
- 0x04 PRESCALE, RW: bits[15:0].
- 0x08 LOAD, RW: 32 bits.
- 0x0C COUNT, RO.
- 0x10 STATUS: bit0 EXP, write 1 to clear.
- Offsets 0x14-0x1C read 0 and ignore writes.
REQ-014 hreadyout_o SHALL be constant 1 (zero wait states); hresp_o SHALL be constant 0 (OKAY).
REQ-015 An address phase is accepted when hsel_i & hready_i & htrans_i[1] are all 1; the offset, write flag and word-size flag are registered.
REQ-016 Write commit:
- A write SHALL commit at the end of its data phase (the cycle after acceptance), using hwdata_i.
- Writes with hsize_i != 3'b010 SHALL be ignored.
REQ-017 hrdata_o SHALL be a combinational mux on the registered offset during a read data phase, and 0 otherwise.
REQ-018 Write then read of the same register back-to-back SHALL return the newly written value.
REQ-019 Prescaler:
- While EN=1, the prescaler counts 0..PRESCALE and asserts tick for one cycle when it equals PRESCALE, then wraps to 0.
- PRESCALE=0 SHALL give a tick every cycle.
REQ-020 On a tick with COUNT!=0, COUNT SHALL decrement by 1.
REQ-021 On a tick with COUNT==0:
- EXP SHALL be set.
- If AUTO=1, COUNT SHALL be reloaded from LOAD.
- If AUTO=0, COUNT SHALL stay 0 and EN SHALL be cleared.
REQ-022 The expiry period SHALL be (LOAD+1)*(PRESCALE+1) cycles.
REQ-023 A LOAD write SHALL also set COUNT=hwdata_i and clear the prescaler; this takes precedence over a same-cycle tick.
REQ-024 A CTRL write with EN=0 SHALL freeze COUNT and clear the prescaler; a write with EN=1 SHALL resume from the frozen COUNT.
REQ-025 A hardware set of EXP and a same-cycle W1C clear SHALL resolve with set winning.
REQ-026 A hardware clear of EN (REQ-021) and a same-cycle CTRL write SHALL resolve with the CTRL write winning.
REQ-027 irq_o SHALL be registered EXP & IRQEN, asserting one cycle after EXP sets.
REQ-028 COUNT arithmetic SHALL be unsigned 32-bit; no wrap below 0.

Reset
REQ-029 On rst_i=1 at a hclk_i edge, the following SHALL be 0: CTRL, PRESCALE, LOAD, COUNT, EXP, the prescaler, the registered address-phase state and irq_o.
REQ-030 A reset mid-transfer SHALL abort the pending data phase with no register write.
REQ-031 hrdata_o SHALL read 0 after reset until the next accepted read.

Structure
REQ-032 Package cm0_timer_pkg SHALL hold:
- the register offset constants;
- the CTRL bit indices;
- the address/data width defaults.
REQ-033 The prescaler SHALL be a sub-module timer_prescaler (inputs clk, rst, enable, clear, limit[15:0]; output tick).

Verification
REQ-034 Reset, then read all five registers -> all return 0; irq_o=0; hreadyout_o=1.
REQ-035 Write PRESCALE=0, LOAD=3, then CTRL=0x7 -> COUNT reads 3,2,1,0 on successive cycles, EXP sets on the 4th tick, COUNT reloads 3, and irq_o rises one cycle later.
REQ-036 PRESCALE=4, LOAD=1, CTRL=0x1 (AUTO=0) -> EXP sets after 10 cycles, EN reads 0, COUNT holds 0, irq_o stays 0.
REQ-037 Write STATUS=1 in the same cycle as an expiry -> EXP remains 1; a later STATUS=1 write -> EXP=0 and irq_o drops one cycle later.
REQ-038 Write LOAD=0x100 while running with COUNT=5 -> the next COUNT read is 0x100; a byte write (hsize_i=0) to LOAD=0xFF -> LOAD unchanged.
REQ-039 Assert rst_i during the data phase of a LOAD write of 0xAA -> LOAD=0 after reset, and back-to-back write/read of PRESCALE=0x1234 then returns 0x1234.

Source files
------------

// File: rtl/cm0_timer_pkg.sv
// Shared constants and types for the AHB3-Lite countdown timer: register
// word indices, CTRL/STATUS bit positions and the bus width defaults.
package cm0_timer_pkg;

    localparam int HADDR_SIZE_DEFAULT = 32;
    localparam int HDATA_SIZE_DEFAULT = 32;

    // Word index taken from haddr[4:2]
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_LOAD     = 3'd2;
    localparam logic [2:0] REG_COUNT    = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_IRQEN_BIT = 1;
    localparam int CTRL_AUTO_BIT  = 2;
    localparam int STATUS_EXP_BIT = 0;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef struct packed {
        logic auto_reload;
        logic irq_en;
        logic en;
    } ctrl_t;

    // Address-phase information carried into the data phase
    typedef struct packed {
        logic       valid;
        logic       write;
        logic       word;
        logic [2:0] index;
    } dphase_t;

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        return {29'd0, c.auto_reload, c.irq_en, c.en};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Cycle prescaler: while enabled, counts 0..limit and pulses tick on the
// cycle the count reaches limit, then wraps to 0.
module timer_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] limit,
    output logic        tick
);

    logic [15:0] cnt_q;

    // >= rather than == so a limit lowered below the running count still
    // wraps on the next cycle instead of running round all 16 bits.
    assign tick = enable & (cnt_q >= limit);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/ahb3lite_timer.sv
// AHB3-Lite slave countdown timer with prescaler, auto-reload and a level
// interrupt; zero wait states, always OKAY.
module ahb3lite_timer
    import cm0_timer_pkg::*;
#(
    parameter int g_haddr_size = HADDR_SIZE_DEFAULT,
    parameter int g_hdata_size = HDATA_SIZE_DEFAULT
) (
    input  logic                    hclk_i,
    input  logic                    rst_i,
    input  logic                    hsel_i,
    input  logic [g_haddr_size-1:0] haddr_i,
    input  logic [g_hdata_size-1:0] hwdata_i,
    output logic [g_hdata_size-1:0] hrdata_o,
    input  logic                    hwrite_i,
    input  logic [2:0]              hsize_i,
    input  logic [2:0]              hburst_i,
    input  logic [3:0]              hprot_i,
    input  logic [1:0]              htrans_i,
    input  logic                    hready_i,
    output logic                    hreadyout_o,
    output logic                    hresp_o,
    output logic                    irq_o
);

    // Handshake: an address phase is taken when hsel & hready & htrans[1]
    // (NONSEQ/SEQ) are high at a clock edge; its data phase is the following
    // cycle, in which hwdata is consumed (write, committed at the next edge) or
    // hrdata is presented (read). hreadyout is always 1, so every data phase
    // completes in one cycle.

    dphase_t     dp_q;
    ctrl_t       ctrl_q;
    logic [15:0] prescale_q;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic        exp_flag_q;

    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_accept;
    logic        wr_commit;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_load;
    logic        wr_status;
    logic        pre_tick;
    logic        pre_clear;
    logic        tick_eff;
    logic        expire;
    logic        unused_inputs;

    assign wdata       = hwdata_i[31:0];
    assign addr_accept = hsel_i & hready_i & htrans_i[1];

    assign hreadyout_o = 1'b1;
    assign hresp_o     = 1'b0;

    assign unused_inputs = ^{hburst_i, hprot_i, htrans_i[0], haddr_i};

    always_ff @(posedge hclk_i) begin
        if (rst_i) begin
            dp_q <= '0;
        end else begin
            dp_q.valid <= addr_accept;
            dp_q.write <= hwrite_i;
            dp_q.word  <= (hsize_i == HSIZE_WORD);
            dp_q.index <= haddr_i[4:2];
        end
    end

    // Sub-word writes are dropped entirely rather than merged.
    assign wr_commit   = dp_q.valid & dp_q.write & dp_q.word;
    assign wr_ctrl     = wr_commit & (dp_q.index == REG_CTRL);
    assign wr_prescale = wr_commit & (dp_q.index == REG_PRESCALE);
    assign wr_load     = wr_commit & (dp_q.index == REG_LOAD);
    assign wr_status   = wr_commit & (dp_q.index == REG_STATUS);

    assign pre_clear = wr_load | (wr_ctrl & ~wdata[CTRL_EN_BIT]);

    timer_prescaler u_prescaler (
        .clk    (hclk_i),
        .rst    (rst_i),
        .enable (ctrl_q.en),
        .clear  (pre_clear),
        .limit  (prescale_q),
        .tick   (pre_tick)
    );

    // A LOAD write restarts the period, so a tick landing on it is discarded.
    assign tick_eff = pre_tick & ~wr_load;
    assign expire   = tick_eff & (count_q == 32'd0);

    always_ff @(posedge hclk_i) begin
        if (rst_i) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            load_q     <= '0;
            count_q    <= '0;
            exp_flag_q <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q.en          <= wdata[CTRL_EN_BIT];
                ctrl_q.irq_en      <= wdata[CTRL_IRQEN_BIT];
                ctrl_q.auto_reload <= wdata[CTRL_AUTO_BIT];
            end else if (expire && !ctrl_q.auto_reload) begin
                ctrl_q.en <= 1'b0;
            end

            if (wr_prescale) begin
                prescale_q <= wdata[15:0];
            end

            if (wr_load) begin
                load_q <= wdata;
            end

            if (wr_load) begin
                count_q <= wdata;
            end else if (tick_eff) begin
                if (count_q != 32'd0) begin
                    count_q <= count_q - 32'd1;
                end else if (ctrl_q.auto_reload) begin
                    count_q <= load_q;
                end
            end

            // Hardware set beats a same-cycle write-1-to-clear.
            if (expire) begin
                exp_flag_q <= 1'b1;
            end else if (wr_status && wdata[STATUS_EXP_BIT]) begin
                exp_flag_q <= 1'b0;
            end

            irq_o <= exp_flag_q & ctrl_q.irq_en;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (dp_q.valid && !dp_q.write) begin
            case (dp_q.index)
                REG_CTRL:     rdata = ctrl_to_word(ctrl_q);
                REG_PRESCALE: rdata = {16'd0, prescale_q};
                REG_LOAD:     rdata = load_q;
                REG_COUNT:    rdata = count_q;
                REG_STATUS:   rdata = {31'd0, exp_flag_q};
                default:      rdata = 32'd0;
            endcase
        end
    end

    assign hrdata_o = rdata;

endmodule

// File: tb/tb_ahb3lite_timer.sv
// Self-checking bench for ahb3lite_timer: directed scenarios plus random bus
// traffic, checked against a cycle-level behavioural model via a scoreboard.
module tb_ahb3lite_timer;
    import cm0_timer_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset / DUT ----------------
    logic         hclk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         hsel_i = 1'b0;
    logic [31:0]  haddr_i = '0;
    logic [31:0]  hwdata_i = '0;
    logic [31:0]  hrdata_o;
    logic         hwrite_i = 1'b0;
    logic [2:0]   hsize_i = 3'b010;
    logic [2:0]   hburst_i = '0;
    logic [3:0]   hprot_i = '0;
    logic [1:0]   htrans_i = '0;
    logic         hready_i = 1'b1;
    logic         hreadyout_o;
    logic         hresp_o;
    logic         irq_o;

    always #5 hclk_i = ~hclk_i;

    ahb3lite_timer #(.g_haddr_size(32), .g_hdata_size(32)) dut (
        .hclk_i      (hclk_i),
        .rst_i       (rst_i),
        .hsel_i      (hsel_i),
        .haddr_i     (haddr_i),
        .hwdata_i    (hwdata_i),
        .hrdata_o    (hrdata_o),
        .hwrite_i    (hwrite_i),
        .hsize_i     (hsize_i),
        .hburst_i    (hburst_i),
        .hprot_i     (hprot_i),
        .htrans_i    (htrans_i),
        .hready_i    (hready_i),
        .hreadyout_o (hreadyout_o),
        .hresp_o     (hresp_o),
        .irq_o       (irq_o)
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic         chk;
        logic [W-1:0] val;
    } dir_t;

    logic [W-1:0] exp_q[$];   // model-predicted read data, in bus order
    dir_t         dir_q[$];   // directed constant expectations, in bus order
    int           n_cmp = 0;
    int           n_bad = 0;
    logic         mon_on = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_en = 0, m_irqen = 0, m_auto = 0, m_exp = 0, m_irq = 0;
    logic [15:0] m_presc = 0;
    logic [31:0] m_load = 0, m_count = 0;
    int          m_run = 0;   // enabled cycles since the prescaler last restarted
    logic        m_dv = 0, m_dw = 0, m_dword = 0, m_rd_pend = 0;
    logic [2:0]  m_didx = 0;

    logic        n_en, n_irqen, n_auto, n_exp;
    logic [15:0] n_presc;
    logic [31:0] n_load, n_count, wd;
    logic        wr, w_ctrl, w_presc, w_load, w_status, tick, hit_zero, restart;

    function automatic logic [31:0] reg_value(input logic [2:0] idx);
        case (idx)
            REG_CTRL:     return {29'd0, m_auto, m_irqen, m_en};
            REG_PRESCALE: return {16'd0, m_presc};
            REG_LOAD:     return m_load;
            REG_COUNT:    return m_count;
            REG_STATUS:   return {31'd0, m_exp};
            default:      return 32'd0;
        endcase
    endfunction

    always @(posedge hclk_i) begin
        m_rd_pend = 1'b0;
        if (rst_i) begin
            m_en = 0; m_irqen = 0; m_auto = 0; m_exp = 0; m_irq = 0;
            m_presc = 0; m_load = 0; m_count = 0; m_run = 0;
            m_dv = 0;
        end else begin
            wd       = hwdata_i;
            wr       = m_dv && m_dw && m_dword;
            w_ctrl   = wr && (m_didx == REG_CTRL);
            w_presc  = wr && (m_didx == REG_PRESCALE);
            w_load   = wr && (m_didx == REG_LOAD);
            w_status = wr && (m_didx == REG_STATUS);
            tick     = m_en && ((m_run % (int'(m_presc) + 1)) == int'(m_presc)) && !w_load;
            hit_zero = tick && (m_count == 0);

            n_en = m_en; n_irqen = m_irqen; n_auto = m_auto; n_exp = m_exp;
            n_presc = m_presc; n_load = m_load; n_count = m_count;

            if (tick && !hit_zero) n_count = m_count - 1;
            if (hit_zero) begin
                n_exp = 1'b1;
                if (m_auto) n_count = m_load;
                else        n_en = 1'b0;
            end
            if (w_status && wd[0] && !hit_zero) n_exp = 1'b0;
            if (w_ctrl) begin
                n_en = wd[0]; n_irqen = wd[1]; n_auto = wd[2];
            end
            if (w_presc) n_presc = wd[15:0];
            if (w_load) begin
                n_load  = wd;
                n_count = wd;
            end

            restart = w_load || (w_ctrl && !wd[0]) || !n_en;
            if (restart)   m_run = 0;
            else if (m_en) m_run = m_run + 1;

            m_irq   = m_exp & m_irqen;
            m_en    = n_en;    m_irqen = n_irqen; m_auto  = n_auto; m_exp = n_exp;
            m_presc = n_presc; m_load  = n_load;  m_count = n_count;

            m_dv    = hsel_i && hready_i && htrans_i[1];
            m_dw    = hwrite_i;
            m_dword = (hsize_i == 3'b010);
            m_didx  = haddr_i[4:2];
            if (m_dv && !m_dw) begin
                exp_q.push_back(reg_value(m_didx));
                m_rd_pend = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [W-1:0] mon_exp;
    dir_t         mon_dir;

    always @(negedge hclk_i) begin
        if (mon_on) begin
            check("ready_resp", {30'd0, hreadyout_o, hresp_o}, 32'd2);
            check("irq", {31'd0, irq_o}, {31'd0, m_irq});
            if (m_rd_pend) begin
                if (exp_q.size() == 0) begin
                    check("rdata_no_expect", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rdata", hrdata_o, mon_exp);
                end
                if (dir_q.size() != 0) begin
                    mon_dir = dir_q.pop_front();
                    if (mon_dir.chk) check("rdata_directed", hrdata_o, mon_dir.val);
                end
            end else begin
                check("rdata_idle", hrdata_o, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] pend_wdata = '0;
    logic        drv_en = 1'b0;   // EN value of the last word CTRL write issued

    task automatic issue(input logic rst, input logic sel, input logic [1:0] trans,
                         input logic rdy, input logic wrt, input logic [4:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input logic chk, input logic [31:0] cv);
        @(posedge hclk_i);
        #1;
        rst_i    = rst;
        hwdata_i = pend_wdata;
        hsel_i   = sel;
        htrans_i = trans;
        hready_i = rdy;
        hwrite_i = wrt;
        haddr_i  = {27'($urandom()), addr};
        hsize_i  = size;
        hburst_i = 3'($urandom());
        hprot_i  = 4'($urandom());
        pend_wdata = wrt ? wdata : $urandom();
        if (rst) drv_en = 1'b0;
        if (wrt && size == 3'b010 && addr[4:2] == REG_CTRL) drv_en = wdata[0];
        if (!rst && sel && rdy && trans[1] && !wrt) dir_q.push_back({chk, cv});
    endtask

    task automatic wr32(input logic [2:0] idx, input logic [31:0] d);
        issue(0, 1, 2'b10, 1, 1, {idx, 2'b00}, 3'b010, d, 0, 0);
    endtask

    task automatic rd(input logic [2:0] idx, input logic chk, input logic [31:0] cv);
        issue(0, 1, 2'b10, 1, 0, {idx, 2'b00}, 3'b010, 0, chk, cv);
    endtask

    task automatic idle();
        issue(0, 0, 2'b00, 1, 0, 5'd0, 3'b010, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  idx;
        logic [31:0] d;
        logic [2:0]  sz;
        int          kind;
        int          v;

        repeat (3) issue(1, 0, 2'b00, 1, 0, 5'd0, 3'b010, 0, 0, 0);
        mon_on = 1'b1;

        // Reset values, including the unused offsets
        for (int i = 0; i < 8; i++) rd(3'(i), 1, 32'd0);

        // Auto-reload countdown with PRESCALE=0
        wr32(REG_PRESCALE, 32'd0);
        wr32(REG_LOAD, 32'd3);
        wr32(REG_CTRL, 32'h7);
        rd(REG_COUNT, 1, 32'd3);
        rd(REG_COUNT, 1, 32'd2);
        rd(REG_COUNT, 1, 32'd1);
        rd(REG_COUNT, 1, 32'd0);
        rd(REG_COUNT, 1, 32'd3);
        rd(REG_STATUS, 1, 32'd1);
        idle(); idle();
        wr32(REG_CTRL, 32'd0);
        wr32(REG_STATUS, 32'd1);
        idle(); idle();

        // One-shot, PRESCALE=4, LOAD=1: expiry ten cycles after enable
        wr32(REG_PRESCALE, 32'd4);
        wr32(REG_LOAD, 32'd1);
        wr32(REG_CTRL, 32'h1);
        for (int j = 1; j <= 12; j++) rd(REG_STATUS, 1, (j >= 11) ? 32'd1 : 32'd0);
        rd(REG_CTRL, 1, 32'd0);
        rd(REG_COUNT, 1, 32'd0);
        repeat (6) idle();
        rd(REG_STATUS, 1, 32'd1);
        wr32(REG_STATUS, 32'd1);
        idle();

        // W1C colliding with an expiry, then a clean clear
        wr32(REG_PRESCALE, 32'd0);
        wr32(REG_LOAD, 32'd3);
        wr32(REG_CTRL, 32'h7);
        rd(REG_COUNT, 1, 32'd3);
        rd(REG_COUNT, 1, 32'd2);
        rd(REG_COUNT, 1, 32'd1);
        wr32(REG_STATUS, 32'd1);
        rd(REG_STATUS, 1, 32'd1);
        wr32(REG_CTRL, 32'd0);
        idle();
        rd(REG_STATUS, 1, 32'd1);
        wr32(REG_STATUS, 32'd1);
        idle();
        rd(REG_STATUS, 1, 32'd0);
        idle(); idle();

        // LOAD write while running; byte write ignored
        wr32(REG_PRESCALE, 32'd1000);
        wr32(REG_LOAD, 32'd5);
        wr32(REG_CTRL, 32'h1);
        rd(REG_COUNT, 1, 32'd5);
        wr32(REG_LOAD, 32'h100);
        rd(REG_COUNT, 1, 32'h100);
        issue(0, 1, 2'b10, 1, 1, {REG_LOAD, 2'b00}, 3'b000, 32'hFF, 0, 0);
        idle();
        rd(REG_LOAD, 1, 32'h100);
        rd(REG_COUNT, 1, 32'h100);
        wr32(REG_CTRL, 32'd0);
        idle();

        // Reset during a LOAD data phase, then back-to-back write/read
        wr32(REG_LOAD, 32'hAA);
        issue(1, 0, 2'b00, 1, 0, 5'd0, 3'b010, 0, 0, 0);
        idle();
        rd(REG_LOAD, 1, 32'd0);
        rd(REG_COUNT, 1, 32'd0);
        rd(REG_PRESCALE, 1, 32'd0);
        wr32(REG_PRESCALE, 32'h1234);
        rd(REG_PRESCALE, 1, 32'h1234);
        idle();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            kind = $urandom_range(0, 99);
            idx  = 3'($urandom_range(0, 7));
            if (kind < 2) begin
                issue(1, 0, 2'b00, 1, 0, 5'd0, 3'b010, 0, 0, 0);
            end else if (kind < 12) begin
                v = $urandom_range(0, 2);
                if (v == 0)      issue(0, 0, 2'b10, 1, 1, {idx, 2'b00}, 3'b010, $urandom(), 0, 0);
                else if (v == 1) issue(0, 1, 2'($urandom_range(0, 1)), 1, 1, {idx, 2'b00}, 3'b010, $urandom(), 0, 0);
                else             issue(0, 1, 2'b10, 0, 1, {idx, 2'b00}, 3'b010, $urandom(), 0, 0);
            end else if (kind < 55 && !(idx == REG_PRESCALE && drv_en)) begin
                case (idx)
                    REG_PRESCALE: d = {16'($urandom()), 16'($urandom_range(0, 3))};
                    REG_LOAD:     d = 32'($urandom_range(0, 6));
                    default:      d = $urandom();
                endcase
                sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
                if (idx == REG_PRESCALE && sz == 3'b010 && drv_en) sz = 3'b000;
                issue(0, 1, {1'b1, 1'($urandom())}, 1, 1, {idx, 2'b00}, sz, d, 0, 0);
            end else begin
                issue(0, 1, {1'b1, 1'($urandom())}, 1, 0, {idx, 2'b00}, 3'($urandom_range(0, 2)), 0, 0, 0);
            end
        end

        repeat (4) idle();
        @(posedge hclk_i);
        #2;
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("dir_queue_drained", 32'(dir_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
